// File: rtl/cpu_run_monitor.sv
// Supervises one program run of a core: holds it in reset, releases it,
// counts cycles and memory strobes, and stops on a halt word or timeout.
module cpu_run_monitor #(
    parameter int                IADDR_W      = 10,
    parameter int                DATA_W       = 32,
    parameter logic [DATA_W-1:0] HALT_WORD    = '0,
    parameter int                HALT_REPEAT  = 1,
    parameter int                RESET_CYCLES = 1,
    parameter int unsigned       TIMEOUT      = 100000,
    parameter int                CNT_W        = 32
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               start,
    input  logic               abort,
    input  logic [DATA_W-1:0]  idata,
    input  logic [IADDR_W-1:0] iaddr,
    input  logic               d_w,
    input  logic               d_r,
    output logic               core_rstn,
    output logic               running,
    output logic               done,
    output logic               timed_out,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   wr_count,
    output logic [CNT_W-1:0]   rd_count,
    output logic [IADDR_W-1:0] halt_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_SETTLE,
        S_RUN,
        S_DONE,
        S_TMO
    } state_t;

    localparam logic [3:0]  HR      = 4'(HALT_REPEAT);
    localparam logic [7:0]  RC_LAST = 8'(RESET_CYCLES - 1);
    localparam logic [63:0] TMO64   = 64'(TIMEOUT);
    localparam bit          TMO_EN  = (TIMEOUT != 0);

    state_t               state_q, state_d;
    logic [7:0]           hold_q, hold_d;
    logic [3:0]           rlen_q, rlen_d;
    logic [CNT_W-1:0]     cyc_q, cyc_d;
    logic [CNT_W-1:0]     wr_q, wr_d;
    logic [CNT_W-1:0]     rd_q, rd_d;
    logic [IADDR_W-1:0]   pc_q, pc_d;
    logic                 rstn_q, rstn_d;
    logic                 run_q, run_d;
    logic                 done_q, done_d;
    logic                 tmo_q, tmo_d;

    logic [CNT_W-1:0]     cyc_inc;
    logic [3:0]           rlen_inc;
    logic                 is_halt;
    logic                 halt_hit;
    logic                 tmo_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign cyc_inc  = sat_inc(cyc_q);
    assign rlen_inc = (&rlen_q) ? rlen_q : rlen_q + 4'd1;
    assign is_halt  = (idata == HALT_WORD);
    assign halt_hit = is_halt && (rlen_inc == HR);
    // Timeout is judged on the count including the current RUN cycle.
    assign tmo_hit  = TMO_EN && (64'(cyc_inc) == TMO64);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rlen_d  = rlen_q;
        cyc_d   = cyc_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        pc_d    = pc_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE, S_TMO: begin
                    if (start) begin
                        state_d = S_HOLD;
                        hold_d  = '0;
                        rlen_d  = '0;
                        cyc_d   = '0;
                        wr_d    = '0;
                        rd_d    = '0;
                        pc_d    = '0;
                    end
                end
                S_HOLD: begin
                    if (hold_q == RC_LAST) begin
                        state_d = S_SETTLE;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                S_SETTLE: begin
                    state_d = S_RUN;
                end
                S_RUN: begin
                    cyc_d  = cyc_inc;
                    rlen_d = is_halt ? rlen_inc : 4'd0;
                    if (d_w) wr_d = sat_inc(wr_q);
                    if (d_r) rd_d = sat_inc(rd_q);
                    if (halt_hit) begin
                        state_d = S_DONE;
                        pc_d    = iaddr;
                    end else if (tmo_hit) begin
                        state_d = S_TMO;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign rstn_d = (state_d == S_SETTLE) || (state_d == S_RUN) ||
                    (state_d == S_DONE) || (state_d == S_TMO);
    assign run_d  = (state_d == S_RUN);
    assign done_d = (state_d == S_DONE);
    assign tmo_d  = (state_d == S_TMO);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            rlen_q  <= '0;
            cyc_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            pc_q    <= '0;
            rstn_q  <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rlen_q  <= rlen_d;
            cyc_q   <= cyc_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            pc_q    <= pc_d;
            rstn_q  <= rstn_d;
            run_q   <= run_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    assign core_rstn   = rstn_q;
    assign running     = run_q;
    assign done        = done_q;
    assign timed_out   = tmo_q;
    assign cycle_count = cyc_q;
    assign wr_count    = wr_q;
    assign rd_count    = rd_q;
    assign halt_pc     = pc_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: a per-cycle vector table plus
// hand sequences for halt repeat, timeout, saturation, reset and abort.
module tb_cpu_run_monitor;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK;
    logic        RSTn;
    logic        start;
    logic        abort;
    logic [31:0] idata;
    logic [9:0]  iaddr;
    logic        d_w;
    logic        d_r;

    logic        a_rstn, a_run, a_done, a_tmo;
    logic [31:0] a_cyc, a_wr, a_rd;
    logic [9:0]  a_pc;
    logic        b_rstn, b_run, b_done, b_tmo;
    logic [31:0] b_cyc, b_wr, b_rd;
    logic [9:0]  b_pc;
    logic        c_rstn, c_run, c_done, c_tmo;
    logic [31:0] c_cyc, c_wr, c_rd;
    logic [9:0]  c_pc;
    logic        d_rstn, d_run, d_done, d_tmo;
    logic [3:0]  d_cyc, d_wr, d_rd;
    logic [9:0]  d_pc;

    int errors = 0;
    int checks = 0;

    cpu_run_monitor u_a (
        .CLK(CLK), .RSTn(RSTn), .start(start), .abort(abort),
        .idata(idata), .iaddr(iaddr), .d_w(d_w), .d_r(d_r),
        .core_rstn(a_rstn), .running(a_run), .done(a_done),
        .timed_out(a_tmo), .cycle_count(a_cyc), .wr_count(a_wr),
        .rd_count(a_rd), .halt_pc(a_pc)
    );

    cpu_run_monitor #(.HALT_REPEAT(3), .RESET_CYCLES(4), .TIMEOUT(0)) u_b (
        .CLK(CLK), .RSTn(RSTn), .start(start), .abort(abort),
        .idata(idata), .iaddr(iaddr), .d_w(d_w), .d_r(d_r),
        .core_rstn(b_rstn), .running(b_run), .done(b_done),
        .timed_out(b_tmo), .cycle_count(b_cyc), .wr_count(b_wr),
        .rd_count(b_rd), .halt_pc(b_pc)
    );

    cpu_run_monitor #(.TIMEOUT(50)) u_c (
        .CLK(CLK), .RSTn(RSTn), .start(start), .abort(abort),
        .idata(idata), .iaddr(iaddr), .d_w(d_w), .d_r(d_r),
        .core_rstn(c_rstn), .running(c_run), .done(c_done),
        .timed_out(c_tmo), .cycle_count(c_cyc), .wr_count(c_wr),
        .rd_count(c_rd), .halt_pc(c_pc)
    );

    cpu_run_monitor #(.CNT_W(4)) u_d (
        .CLK(CLK), .RSTn(RSTn), .start(start), .abort(abort),
        .idata(idata), .iaddr(iaddr), .d_w(d_w), .d_r(d_r),
        .core_rstn(d_rstn), .running(d_run), .done(d_done),
        .timed_out(d_tmo), .cycle_count(d_cyc), .wr_count(d_wr),
        .rd_count(d_rd), .halt_pc(d_pc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        st;
        logic [31:0] id;
        logic [9:0]  ia;
        logic        dw;
        logic        dr;
        logic        e_rstn;
        logic        e_run;
        logic        e_done;
        logic [31:0] e_cyc;
        logic [31:0] e_wr;
        logic [31:0] e_rd;
        logic [9:0]  e_pc;
    } vec_t;

    vec_t        tbl [15];
    logic [31:0] seq [6];
    logic        seq_done [6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTn  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        d_w   = 1'b0;
        d_r   = 1'b0;
        idata = NOP;
        iaddr = '0;
        tick();
        tick();
        RSTn = 1'b1;
        tick();
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        tbl[0]  = '{1, NOP,   10'h000, 0, 0, 0, 0, 0, 0,  0, 0, 10'h000};
        tbl[1]  = '{0, NOP,   10'h000, 0, 0, 1, 0, 0, 0,  0, 0, 10'h000};
        tbl[2]  = '{0, NOP,   10'h000, 1, 0, 1, 1, 0, 0,  0, 0, 10'h000};
        tbl[3]  = '{0, NOP,   10'h004, 1, 1, 1, 1, 0, 1,  1, 1, 10'h000};
        tbl[4]  = '{0, NOP,   10'h008, 1, 0, 1, 1, 0, 2,  2, 1, 10'h000};
        tbl[5]  = '{0, NOP,   10'h00c, 1, 1, 1, 1, 0, 3,  3, 2, 10'h000};
        tbl[6]  = '{0, NOP,   10'h010, 0, 1, 1, 1, 0, 4,  3, 3, 10'h000};
        tbl[7]  = '{0, NOP,   10'h014, 1, 0, 1, 1, 0, 5,  4, 3, 10'h000};
        tbl[8]  = '{0, NOP,   10'h018, 1, 1, 1, 1, 0, 6,  5, 4, 10'h000};
        tbl[9]  = '{0, NOP,   10'h01c, 1, 0, 1, 1, 0, 7,  6, 4, 10'h000};
        tbl[10] = '{0, NOP,   10'h020, 1, 0, 1, 1, 0, 8,  7, 4, 10'h000};
        tbl[11] = '{0, NOP,   10'h024, 0, 0, 1, 1, 0, 9,  7, 4, 10'h000};
        tbl[12] = '{0, 32'h0, 10'h028, 0, 0, 1, 0, 1, 10, 7, 4, 10'h028};
        tbl[13] = '{0, 32'h0, 10'h02c, 1, 1, 1, 0, 1, 10, 7, 4, 10'h028};
        tbl[14] = '{1, NOP,   10'h000, 0, 0, 0, 0, 0, 0,  0, 0, 10'h000};
        seq      = '{32'h0, 32'h0, 32'h5, 32'h0, 32'h0, 32'h0};
        seq_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        do_reset();
        chk("rst_a_rstn", a_rstn, 0);
        chk("rst_a_flags", {a_run, a_done, a_tmo}, 0);
        chk("rst_a_cnt", {a_cyc, a_wr}, 0);
        chk("rst_a_rd_pc", {a_rd, a_pc}, 0);
        chk("rst_b_flags", {b_rstn, b_run, b_done, b_tmo}, 0);

        for (int i = 0; i < 15; i++) begin
            start = tbl[i].st;
            idata = tbl[i].id;
            iaddr = tbl[i].ia;
            d_w   = tbl[i].dw;
            d_r   = tbl[i].dr;
            tick();
            chk($sformatf("vec%0d_rstn", i), a_rstn, tbl[i].e_rstn);
            chk($sformatf("vec%0d_run", i), a_run, tbl[i].e_run);
            chk($sformatf("vec%0d_done", i), a_done, tbl[i].e_done);
            chk($sformatf("vec%0d_cyc", i), a_cyc, tbl[i].e_cyc);
            chk($sformatf("vec%0d_wr", i), a_wr, tbl[i].e_wr);
            chk($sformatf("vec%0d_rd", i), a_rd, tbl[i].e_rd);
            chk($sformatf("vec%0d_pc", i), a_pc, tbl[i].e_pc);
        end

        // Halt on the 20th RUN cycle at 0x028.
        do_reset();
        launch();
        chk("h20_hold_rstn", a_rstn, 0);
        tick();
        chk("h20_settle", {a_rstn, a_run}, 2'b10);
        tick();
        chk("h20_run", a_run, 1);
        repeat (19) tick();
        idata = 32'h0;
        iaddr = 10'h028;
        tick();
        chk("h20_done", {a_rstn, a_run, a_done, a_tmo}, 4'b1010);
        chk("h20_cyc", a_cyc, 20);
        chk("h20_pc", a_pc, 10'h028);

        // Reset length 4 and halt repeat 3.
        do_reset();
        launch();
        n = 0;
        while (!b_rstn && n < 20) begin
            n++;
            tick();
        end
        chk("b_hold_len", n, 4);
        chk("b_settle_run", b_run, 0);
        tick();
        chk("b_run", b_run, 1);
        for (int i = 0; i < 6; i++) begin
            idata = seq[i];
            iaddr = 10'h100 + 10'(4 * i);
            tick();
            chk($sformatf("b_seq%0d_done", i), b_done, seq_done[i]);
        end
        chk("b_pc", b_pc, 10'h114);
        chk("b_cyc", b_cyc, 6);
        idata = NOP;

        // Timeout at 50, then halt on cycle 50 wins.
        do_reset();
        launch();
        tick();
        tick();
        repeat (49) tick();
        chk("c_pre_tmo", {c_run, c_tmo}, 2'b10);
        chk("c_pre_cyc", c_cyc, 49);
        tick();
        chk("c_tmo", {c_rstn, c_run, c_done, c_tmo}, 4'b1001);
        chk("c_tmo_cyc", c_cyc, 50);
        tick();
        chk("c_tmo_frozen", c_cyc, 50);
        chk("c_tmo_held", c_tmo, 1);
        launch();
        chk("c_restart", {c_rstn, c_tmo}, 2'b00);
        chk("c_restart_cyc", c_cyc, 0);
        tick();
        tick();
        repeat (49) tick();
        idata = 32'h0;
        tick();
        idata = NOP;
        chk("c_tie_flags", {c_done, c_tmo}, 2'b10);
        chk("c_tie_cyc", c_cyc, 50);

        // Saturation with 4-bit counters.
        do_reset();
        launch();
        tick();
        tick();
        d_w = 1'b1;
        repeat (20) tick();
        d_w = 1'b0;
        chk("d_wr_sat", d_wr, 15);
        chk("d_cyc_sat", d_cyc, 15);

        // Async reset mid-RUN, then abort mid-RUN.
        do_reset();
        launch();
        tick();
        tick();
        d_w = 1'b1;
        repeat (5) tick();
        chk("ar_pre_cyc", a_cyc, 5);
        #2;
        RSTn = 1'b0;
        #1;
        chk("ar_async_flags", {a_rstn, a_run}, 0);
        chk("ar_async_cnt", {a_cyc, a_wr}, 0);
        tick();
        RSTn = 1'b1;
        tick();
        chk("ar_idle", {a_rstn, a_run, a_done}, 0);
        launch();
        tick();
        tick();
        repeat (5) tick();
        abort = 1'b1;
        start = 1'b1;
        idata = 32'h0;
        tick();
        chk("ab_flags", {a_rstn, a_run, a_done, a_tmo}, 0);
        chk("ab_cyc_held", a_cyc, 5);
        chk("ab_wr_held", a_wr, 5);
        abort = 1'b0;
        start = 1'b0;
        idata = NOP;
        d_w   = 1'b0;
        tick();
        chk("ab_stay_idle", {a_rstn, a_run, a_cyc}, 0 | 64'd5);
        launch();
        chk("ab_restart_hold", a_rstn, 0);
        chk("ab_restart_clr", a_cyc, 0);
        tick();
        chk("ab_restart_settle", {a_rstn, a_run}, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
